// File: rtl/instr_ingress_arbiter_pkg.sv
// Shared types and helpers for the instruction ingress arbiter.
// Holds the FSM state encoding, the default word width and a clog2 helper.
package instr_ingress_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DATA_W_DEFAULT = 64;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/instr_ingress_arbiter_rr_picker.sv
// Combinational round-robin scan: first set request bit after rr_last, with wrap.
// Requester rr_last itself is checked last, so it has the lowest priority.
module instr_ingress_arbiter_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_last,
    output logic [IDX_W-1:0]   pick,
    output logic               any_valid
);

    // Scan from the farthest candidate back to the nearest one, so the nearest
    // set bit after rr_last is the one left in pick.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick      = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_last) + k) % NUM_REQ);
            if (req[cand]) begin
                pick      = cand;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_ingress_arbiter.sv
// Round-robin arbiter sharing the instruction buffer write port between requesters.
// Groups are never interleaved; each grant is bounded by a burst limit and an idle timeout.
module instr_ingress_arbiter
    import instr_ingress_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int REQ_IDX_W    = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ),
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int MAX_BURST    = 4,
    parameter int HOLD_TIMEOUT = 8
) (
    input  logic                      external_clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      buf_full,
    output logic                      buf_wr_en,
    output logic [DATA_W-1:0]         buf_wr_data,
    output logic [REQ_IDX_W-1:0]      grant_id,
    output logic                      grant_active,
    output logic                      abort_err,
    output logic [15:0]               word_count
);

    state_t                 state_q, state_d;
    logic [REQ_IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [REQ_IDX_W-1:0]   rr_last_q, rr_last_d;
    logic [7:0]             burst_cnt_q, burst_cnt_d;
    logic [7:0]             idle_cnt_q, idle_cnt_d;
    logic [15:0]            word_count_q, word_count_d;
    logic                   buf_wr_en_q, buf_wr_en_d;
    logic [DATA_W-1:0]      buf_wr_data_q, buf_wr_data_d;
    logic                   grant_active_q, grant_active_d;
    logic                   abort_err_q, abort_err_d;

    logic [REQ_IDX_W-1:0]   pick;
    logic                   any_valid;
    logic                   g_valid;
    logic                   g_last;
    logic [DATA_W-1:0]      g_data;
    logic                   xfer;

    instr_ingress_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_IDX_W)
    ) u_rr_picker (
        .req       (req_valid),
        .rr_last   (rr_last_q),
        .pick      (pick),
        .any_valid (any_valid)
    );

    assign g_valid = req_valid[grant_id_q];
    assign g_last  = req_last[grant_id_q];
    assign g_data  = req_data[grant_id_q*DATA_W +: DATA_W];
    assign xfer    = (state_q == GRANT) && g_valid && !buf_full && !rst;

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == GRANT && !buf_full) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        rr_last_d     = rr_last_q;
        burst_cnt_d   = burst_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        word_count_d  = word_count_q;
        buf_wr_en_d   = 1'b0;
        buf_wr_data_d = buf_wr_data_q;
        abort_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d     = GRANT;
                    grant_id_d  = pick;
                    rr_last_d   = pick;
                    burst_cnt_d = 8'd0;
                    idle_cnt_d  = 8'd0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    buf_wr_en_d   = 1'b1;
                    buf_wr_data_d = g_data;
                    word_count_d  = word_count_q + 16'd1;
                    burst_cnt_d   = burst_cnt_q + 8'd1;
                    idle_cnt_d    = 8'd0;
                    if (g_last || (burst_cnt_q + 8'd1) == 8'(MAX_BURST)) begin
                        state_d = IDLE;
                    end
                end else if (!g_valid) begin
                    // Only an absent requester counts towards the timeout, not buffer back-pressure.
                    idle_cnt_d = idle_cnt_q + 8'd1;
                    if ((idle_cnt_q + 8'd1) == 8'(HOLD_TIMEOUT)) begin
                        state_d     = IDLE;
                        abort_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        grant_active_d = (state_d == GRANT);
    end

    always_ff @(posedge external_clk) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_id_q     <= '0;
            rr_last_q      <= REQ_IDX_W'(NUM_REQ - 1);
            burst_cnt_q    <= 8'd0;
            idle_cnt_q     <= 8'd0;
            word_count_q   <= 16'd0;
            buf_wr_en_q    <= 1'b0;
            buf_wr_data_q  <= '0;
            grant_active_q <= 1'b0;
            abort_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            rr_last_q      <= rr_last_d;
            burst_cnt_q    <= burst_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            word_count_q   <= word_count_d;
            buf_wr_en_q    <= buf_wr_en_d;
            buf_wr_data_q  <= buf_wr_data_d;
            grant_active_q <= grant_active_d;
            abort_err_q    <= abort_err_d;
        end
    end

    assign buf_wr_en    = buf_wr_en_q;
    assign buf_wr_data  = buf_wr_data_q;
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;
    assign abort_err    = abort_err_q;
    assign word_count   = word_count_q;

endmodule

// File: doc/instr_ingress_arbiter.md
Name: instr_ingress_arbiter

Overview:
Shares the instruction buffer's single write port (external_clk domain) between NUM_REQ host-side requesters. Each requester streams 64-bit instruction words with a valid/ready handshake and marks atomic groups with a last flag. Grants are round-robin, and a group is never interleaved with another requester's words. The block honours the buffer's full flag, bounds each grant by a burst limit and a hold timeout, and keeps an accepted-word count.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REQ_IDX_W, 2, width of the grant index, equal to clog2(NUM_REQ)
DATA_W, 64, instruction word width
MAX_BURST, 4, maximum words per grant before forced release (1..255)
HOLD_TIMEOUT, 8, consecutive idle cycles of the granted requester before forced release (1..255)

Ports:
external_clk  in  1  clock; all logic is on this edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*DATA_W  requester i drives bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  word is the last of an atomic group
req_ready  out  NUM_REQ  per-requester accept, combinational
buf_full  in  1  instruction buffer full flag
buf_wr_en  out  1  registered write strobe to the buffer
buf_wr_data  out  DATA_W  registered write data
grant_id  out  REQ_IDX_W  index of the current or last granted requester
grant_active  out  1  high while in GRANT
abort_err  out  1  one-cycle pulse on timeout release
word_count  out  16  total accepted words, wraps at 2^16

Behaviour:
- Reset, evaluated on the external_clk edge while rst=1, with priority over every other action:
  - state=IDLE
  - buf_wr_en=0, buf_wr_data=0
  - grant_id=0, grant_active=0, abort_err=0, word_count=0
  - burst_cnt=0, idle_cnt=0
  - rr_last=NUM_REQ-1, so requester 0 has first priority
- Reset mid-grant drops the grant immediately. A word presented in the rst cycle is not accepted; req_ready=0 during rst.
- States: IDLE, GRANT.
- IDLE:
  - req_ready=0.
  - If any req_valid is set, pick the first set bit scanning from (rr_last+1) mod NUM_REQ upward with wrap.
  - Next cycle: state=GRANT, grant_id=pick, rr_last=pick, burst_cnt=0, idle_cnt=0.
  - If no req_valid is set, remain in IDLE.
- GRANT, accept rule:
  - req_ready[grant_id] = !buf_full; every other req_ready bit is 0.
  - A transfer happens when req_valid[g] && req_ready[g] (g = grant_id).
- On a transfer:
  - Next cycle: buf_wr_en=1 and buf_wr_data=req_data[g]. Latency from handshake to write is 1 cycle.
  - word_count+1, burst_cnt+1, idle_cnt=0.
- On a cycle with no transfer: buf_wr_en=0 next cycle.
- Release to IDLE, registered, any of:
  - (a) a transfer with req_last[g]=1
  - (b) a transfer making burst_cnt reach MAX_BURST
  - (c) idle_cnt reaching HOLD_TIMEOUT
- idle_cnt increments each GRANT cycle where req_valid[g]=0. Cycles stalled by buf_full with valid high do not count, since that back-pressure is not the requester's fault.
- On (c), abort_err pulses for 1 cycle, coincident with the return to IDLE.
- On (b) without last, the group is split. The requester re-arbitrates from IDLE and is now lowest priority.
- There is one IDLE bubble cycle between grants. Maximum throughput is MAX_BURST words per MAX_BURST+1 cycles.
- buf_full high: no transfers and no idle_cnt advance. The grant is held indefinitely.
- Single requester active: it is re-granted after each bubble.
- NUM_REQ=1: the scan is trivial; behaviour is otherwise identical.
- grant_active = (state==GRANT), registered.
- grant_id holds its value in IDLE.
- All arithmetic is unsigned.
  - burst_cnt and idle_cnt are 8-bit; parameters are restricted to at most 255 so they never overflow.
  - word_count wraps modulo 2^16.

Decomposition:
- Shared package: state encoding (IDLE=0, GRANT=1), DATA_W default, a clog2 helper constant function.
- Sub-module rr_picker: combinational round-robin priority scan. Inputs: req vector, rr_last. Outputs: pick index and any_valid.
- FSM, counters and datapath register stay in instr_ingress_arbiter.

Test Plan:
- Reset: rst high 2 cycles with all req_valid=1 -> req_ready=0, buf_wr_en=0, word_count=0. First grant after release is requester 0.
- Round-robin: all four requesters hold 1-word groups (last=1), data 0xA0..0xA3 -> buffer writes in order A0,A1,A2,A3,A0, each separated by one idle cycle; word_count=5.
- Atomic group with contention: requester 2 sends 3 words (0x10,0x11,0x12 with last on 0x12) while requester 3 is valid -> three consecutive writes 0x10..0x12, then requester 3's word.
- Burst split: MAX_BURST=4, requester 1 sends 6 words with no last, requester 0 also valid -> 4 words from requester 1, then requester 0, then the remaining 2 words from requester 1.
- Back-pressure: buf_full=1 for 5 cycles mid-group -> req_ready=0, no writes, no abort_err. Resumes with no lost or duplicated word; word_count is exact.
- Timeout: granted requester drops valid for 8 cycles -> abort_err pulses once, FSM returns to IDLE, next requester is granted.
